// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: fetch-side redirect generator.
// Combines a direct-mapped BHT of 2-bit counters with a tagged BTB to predict
// taken branches at fetch time, detects mispredicts reported by execute,
// flushes younger work, and holds a corrective redirect until fetch can take it.
//
// Optional build macro: REDIRECT_STATS_EN
//   When defined, adds o_resolve_count and o_mispredict_count (32-bit, wrapping).
//
// Load handshake: o_load_we is the valid and !i_stall is the ready. A redirect
// is consumed only in a cycle where both are high. A mispredict raised while
// ready is low is parked in HOLD and re-presented every cycle until ready.
// Predicted loads are not held; they are simply not offered while stalled.
module branch_redirect_unit #(
    parameter int ADDR_WIDTH = 26,
    parameter int IDX_BITS   = 6,
    parameter int TAG_BITS   = ADDR_WIDTH - 2 - IDX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_fetch_pc,
    input  logic                  i_stall,
    input  logic                  i_res_valid,
    input  logic [ADDR_WIDTH-1:0] i_res_pc,
    input  logic                  i_res_taken,
    input  logic [ADDR_WIDTH-1:0] i_res_target,
    input  logic                  i_res_pred_taken,
    input  logic [ADDR_WIDTH-1:0] i_res_pred_target,
    output logic                  o_load_we,
    output logic [ADDR_WIDTH-1:0] o_load_pc,
    output logic                  o_pred_taken,
    output logic                  o_flush,
`ifdef REDIRECT_STATS_EN
    output logic [31:0]           o_resolve_count,
    output logic [31:0]           o_mispredict_count,
`endif
    output logic                  o_dbg_state
);

    localparam int DEPTH = 2 ** IDX_BITS;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } pend_state_e;

    pend_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;

    logic [1:0]            cnt_q   [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_q   [DEPTH];

    logic [IDX_BITS-1:0]   idx;
    logic [IDX_BITS-1:0]   ridx;
    logic [TAG_BITS-1:0]   ftag;
    logic [TAG_BITS-1:0]   rtag;
    logic                  hit;
    logic                  pred;
    logic                  pend;
    logic                  accept;
    logic                  mis;
    logic [ADDR_WIDTH-1:0] fix;
    logic [1:0]            cnt_nxt;
    logic                  unused_lsbs;

    // Instructions are word aligned, so the two low PC bits carry no information.
    assign unused_lsbs = ^{i_fetch_pc[1:0], i_res_pc[1:0]};

    // Fetch-side lookup, zero latency; sees table contents before this cycle's update.
    assign idx  = i_fetch_pc[IDX_BITS+1:2];
    assign ftag = i_fetch_pc[ADDR_WIDTH-1:IDX_BITS+2];
    assign hit  = valid_q[idx] && (tag_q[idx] == ftag);
    assign pred = hit && cnt_q[idx][1];

    // Resolutions arriving while a redirect is parked are wrong-path and dropped.
    assign pend   = (state_q == ST_HOLD);
    assign accept = i_res_valid && !pend;
    assign mis    = accept &&
                    ((i_res_taken != i_res_pred_taken) ||
                     (i_res_taken && (i_res_target != i_res_pred_target)));
    assign fix    = i_res_taken ? i_res_target : (i_res_pc + ADDR_WIDTH'(4));

    assign ridx = i_res_pc[IDX_BITS+1:2];
    assign rtag = i_res_pc[ADDR_WIDTH-1:IDX_BITS+2];

    // Saturating 2-bit counter step for the resolving entry.
    always_comb begin
        cnt_nxt = cnt_q[ridx];
        if (i_res_taken) begin
            if (cnt_q[ridx] != 2'b11) cnt_nxt = cnt_q[ridx] + 2'b01;
        end else begin
            if (cnt_q[ridx] != 2'b00) cnt_nxt = cnt_q[ridx] - 2'b01;
        end
    end

    // Output mux: parked redirect, then fresh mispredict, then prediction.
    always_comb begin
        o_load_we    = 1'b0;
        o_load_pc    = '0;
        o_pred_taken = 1'b0;
        o_flush      = 1'b0;
        if (rst_n) begin
            o_pred_taken = pred && !i_stall;
            o_flush      = mis;
            if (pend) begin
                o_load_we = 1'b1;
                o_load_pc = pend_pc_q;
            end else if (mis) begin
                o_load_we = 1'b1;
                o_load_pc = fix;
            end else if (pred && !i_stall) begin
                o_load_we = 1'b1;
                o_load_pc = tgt_q[idx];
            end
        end
    end

    // Pending FSM next state: park a mispredict that fetch cannot take yet.
    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (mis && i_stall) begin
                    state_d   = ST_HOLD;
                    pend_pc_d = fix;
                end
            end
            ST_HOLD: begin
                if (!i_stall) state_d = ST_IDLE;
            end
        endcase
    end

    // Pending FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // BHT/BTB training from accepted resolutions; not-taken leaves the BTB alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= 2'b01;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (accept) begin
            cnt_q[ridx] <= cnt_nxt;
            if (i_res_taken) begin
                valid_q[ridx] <= 1'b1;
                tag_q[ridx]   <= rtag;
                tgt_q[ridx]   <= i_res_target;
            end
        end
    end

    assign o_dbg_state = state_q;

`ifdef REDIRECT_STATS_EN
    logic [31:0] res_cnt_q;
    logic [31:0] mis_cnt_q;

    // Event counters for accepted resolutions and mispredicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (accept) res_cnt_q <= res_cnt_q + 32'd1;
            if (mis)    mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign o_resolve_count    = res_cnt_q;
    assign o_mispredict_count = mis_cnt_q;
`endif

endmodule
